// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with optional first-word-fall-through output, programmable
// almost-full/almost-empty thresholds, occupancy count and sticky error flags.
module sync_fifo_flags #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned FIFO_WIDTH = 32,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 4,
  parameter int unsigned AE_LEVEL   = 4,
  localparam int unsigned AW        = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [FIFO_WIDTH-1:0] din,
  input  logic                  ren,
  output logic [FIFO_WIDTH-1:0] dout,
  output logic                  dvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [AW:0]           count,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [AW:0] DepthCnt = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] AfCnt    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AeCnt    = (AW+1)'(AE_LEVEL);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q, af_q, ae_q;
  logic          overflow_q, overflow_d, underflow_q, underflow_d;
  logic          wr_acc, rd_acc;

  // Accepts use the registered pre-edge flags, so a write into an empty FIFO
  // can never be read back in the same cycle.
  assign wr_acc = wen & ~full_q;
  assign rd_acc = ren & ~empty_q;

  always_comb begin
    count_d     = count_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
    overflow_d  = (overflow_q & ~err_clr) | (wen & full_q);
    underflow_d = (underflow_q & ~err_clr) | (ren & empty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      full_q      <= (count_d == DepthCnt);
      empty_q     <= (count_d == '0);
      af_q        <= (count_d >= AfCnt);
      ae_q        <= (count_d <= AeCnt);
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr_q] <= din;
  end

  if (FWFT != 0) begin : gen_fwft
    // Gated so dout reads 0 rather than stale storage while empty.
    assign dout   = empty_q ? '0 : mem[rd_ptr_q];
    assign dvalid = ~empty_q;
  end else begin : gen_std
    logic [FIFO_WIDTH-1:0] dout_q;
    logic                  dvalid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q   <= '0;
        dvalid_q <= 1'b0;
      end else begin
        dvalid_q <= rd_acc;
        if (rd_acc) dout_q <= mem[rd_ptr_q];
      end
    end

    assign dout   = dout_q;
    assign dvalid = dvalid_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a standard-mode instance checked by vector table and a queue-based
// reference model, plus a FWFT instance checked with hand-written sequences.
module tb_sync_fifo_flags;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned AF    = DEPTH - 4;
  localparam int unsigned AE    = 4;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Standard-mode instance
  logic             s_rst, s_wen, s_ren, s_clr;
  logic [WIDTH-1:0] s_din, s_dout;
  logic             s_dvalid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [AW:0]      s_count;

  sync_fifo_flags #(
    .FIFO_DEPTH(DEPTH), .FIFO_WIDTH(WIDTH), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) u_std (
    .clk(clk), .rst(s_rst), .wen(s_wen), .din(s_din), .ren(s_ren), .dout(s_dout),
    .dvalid(s_dvalid), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .err_clr(s_clr), .overflow(s_ovf),
    .underflow(s_unf)
  );

  // FWFT instance
  logic             f_rst, f_wen, f_ren, f_clr;
  logic [WIDTH-1:0] f_din, f_dout;
  logic             f_dvalid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [AW:0]      f_count;

  sync_fifo_flags #(
    .FIFO_DEPTH(DEPTH), .FIFO_WIDTH(WIDTH), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) u_fwft (
    .clk(clk), .rst(f_rst), .wen(f_wen), .din(f_din), .ren(f_ren), .dout(f_dout),
    .dvalid(f_dvalid), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .err_clr(f_clr), .overflow(f_ovf),
    .underflow(f_unf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, expected read port and sticky errors
  logic [WIDTH-1:0] mq[$];
  logic             m_ovf, m_unf, m_dvalid;
  logic [WIDTH-1:0] m_dout;
  int               acc_writes;

  task automatic model_step(input logic rst, input logic wen, input logic [WIDTH-1:0] din,
                            input logic ren, input logic clr);
    bit was_full, was_empty;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_unf = 0; m_dvalid = 0; m_dout = '0;
    end else begin
      m_dvalid = 0;
      if (ren && !was_empty) begin
        m_dout   = mq.pop_front();
        m_dvalid = 1;
      end
      if (wen && !was_full) begin
        mq.push_back(din);
        acc_writes++;
      end
      m_ovf = (m_ovf && !clr) || (wen && was_full);
      m_unf = (m_unf && !clr) || (ren && was_empty);
    end
  endtask

  task automatic drive_std(input logic rst, input logic wen, input logic [WIDTH-1:0] din,
                           input logic ren, input logic clr);
    s_rst = rst; s_wen = wen; s_din = din; s_ren = ren; s_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_std(input logic rst, input logic wen, input logic [WIDTH-1:0] din,
                         input logic ren, input logic clr);
    int n;
    drive_std(rst, wen, din, ren, clr);
    model_step(rst, wen, din, ren, clr);
    n = mq.size();
    chk("count",        64'(s_count), 64'(n));
    chk("full",         64'(s_full),  64'(n == DEPTH));
    chk("empty",        64'(s_empty), 64'(n == 0));
    chk("almost_full",  64'(s_af),    64'(n >= AF));
    chk("almost_empty", 64'(s_ae),    64'(n <= AE));
    chk("overflow",     64'(s_ovf),   64'(m_ovf));
    chk("underflow",    64'(s_unf),   64'(m_unf));
    chk("dvalid",       64'(s_dvalid), 64'(m_dvalid));
    chk("dout",         64'(s_dout),  64'(m_dout));
  endtask

  task automatic cyc_fwft(input logic rst, input logic wen, input logic [WIDTH-1:0] din,
                          input logic ren);
    f_rst = rst; f_wen = wen; f_din = din; f_ren = ren; f_clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic             rst, wen, ren, clr;
    logic [WIDTH-1:0] din;
    int               cnt;
    logic             ovf, unf, dvalid;
    logic [WIDTH-1:0] dout;
  } vec_t;

  vec_t vecs[11];

  initial begin
    s_rst = 1; s_wen = 0; s_ren = 0; s_clr = 0; s_din = '0;
    f_rst = 1; f_wen = 0; f_ren = 0; f_clr = 0; f_din = '0;
    m_ovf = 0; m_unf = 0; m_dvalid = 0; m_dout = '0; acc_writes = 0;

    //           rst wen ren clr  din    cnt ovf unf dv  dout
    vecs[0]  = '{1, 0, 0, 0, 32'h0,  0, 0, 0, 0, 32'h0};
    vecs[1]  = '{0, 0, 1, 0, 32'h0,  0, 0, 1, 0, 32'h0};
    vecs[2]  = '{0, 0, 0, 1, 32'h0,  0, 0, 0, 0, 32'h0};
    vecs[3]  = '{0, 1, 0, 0, 32'h11, 1, 0, 0, 0, 32'h0};
    vecs[4]  = '{0, 1, 1, 0, 32'h22, 1, 0, 0, 1, 32'h11};
    vecs[5]  = '{0, 0, 1, 0, 32'h0,  0, 0, 0, 1, 32'h22};
    vecs[6]  = '{0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 32'h22};
    vecs[7]  = '{0, 1, 1, 0, 32'h33, 1, 0, 1, 0, 32'h22};
    vecs[8]  = '{0, 0, 1, 1, 32'h0,  0, 0, 0, 1, 32'h33};
    vecs[9]  = '{0, 0, 1, 1, 32'h0,  0, 0, 1, 0, 32'h33};
    vecs[10] = '{1, 1, 1, 0, 32'h44, 0, 0, 0, 0, 32'h0};

    for (int i = 0; i < 11; i++) begin
      drive_std(vecs[i].rst, vecs[i].wen, vecs[i].din, vecs[i].ren, vecs[i].clr);
      chk($sformatf("vec%0d.count", i),  64'(s_count),  64'(vecs[i].cnt));
      chk($sformatf("vec%0d.empty", i),  64'(s_empty),  64'(vecs[i].cnt == 0));
      chk($sformatf("vec%0d.full", i),   64'(s_full),   64'(0));
      chk($sformatf("vec%0d.ae", i),     64'(s_ae),     64'(1));
      chk($sformatf("vec%0d.af", i),     64'(s_af),     64'(0));
      chk($sformatf("vec%0d.ovf", i),    64'(s_ovf),    64'(vecs[i].ovf));
      chk($sformatf("vec%0d.unf", i),    64'(s_unf),    64'(vecs[i].unf));
      chk($sformatf("vec%0d.dvalid", i), 64'(s_dvalid), 64'(vecs[i].dvalid));
      chk($sformatf("vec%0d.dout", i),   64'(s_dout),   64'(vecs[i].dout));
    end

    // Reset held for two cycles
    cyc_std(1, 0, '0, 0, 0);
    cyc_std(1, 0, '0, 0, 0);

    // Fill 0..63 then one write into full
    for (int i = 0; i < DEPTH; i++) cyc_std(0, 1, WIDTH'(i), 0, 0);
    chk("fill.full", 64'(s_full), 64'(1));
    cyc_std(0, 1, 32'hDEAD, 0, 0);
    chk("ovf.count", 64'(s_count), 64'(DEPTH));
    chk("ovf.flag",  64'(s_ovf),   64'(1));

    // Drain in order, then a read from empty, then clear both errors
    for (int i = 0; i < DEPTH; i++) cyc_std(0, 0, '0, 1, 0);
    chk("drain.last", 64'(s_dout), 64'(DEPTH - 1));
    cyc_std(0, 0, '0, 1, 0);
    chk("unf.flag", 64'(s_unf), 64'(1));
    cyc_std(0, 0, '0, 0, 1);

    // Simultaneous push/pop at count 10, full and empty
    for (int i = 0; i < 10; i++) cyc_std(0, 1, WIDTH'(100 + i), 0, 0);
    for (int i = 0; i < 20; i++) cyc_std(0, 1, WIDTH'(200 + i), 1, 0);
    chk("simul.count10", 64'(s_count), 64'(10));
    while (mq.size() < DEPTH) cyc_std(0, 1, $urandom, 0, 0);
    cyc_std(0, 1, 32'hBEEF, 1, 0);
    chk("full_rw.count", 64'(s_count), 64'(DEPTH - 1));
    while (mq.size() > 0) cyc_std(0, 0, '0, 1, 1);
    cyc_std(0, 1, 32'hCAFE, 1, 0);
    chk("empty_rw.count", 64'(s_count), 64'(1));
    chk("empty_rw.unf",   64'(s_unf),   64'(1));

    // Random traffic with alternating fill/drain bias to force pointer wrap
    acc_writes = 0;
    for (int i = 0; i < 1200; i++) begin
      int pw;
      pw = ((i / 100) % 2 == 0) ? 70 : 30;
      cyc_std(($urandom_range(0, 499) == 0), ($urandom_range(0, 99) < pw), $urandom,
              ($urandom_range(0, 99) < 100 - pw), ($urandom_range(0, 31) == 0));
    end
    $display("[TB] random phase accepted %0d writes", acc_writes);

    // FWFT instance
    cyc_fwft(1, 0, '0, 0);
    cyc_fwft(1, 0, '0, 0);
    chk("fwft.rst.empty",  64'(f_empty),  64'(1));
    chk("fwft.rst.dvalid", 64'(f_dvalid), 64'(0));
    chk("fwft.rst.dout",   64'(f_dout),   64'(0));
    cyc_fwft(0, 1, 32'hA5, 0);
    chk("fwft.a5.dvalid", 64'(f_dvalid), 64'(1));
    chk("fwft.a5.dout",   64'(f_dout),   64'(32'hA5));
    cyc_fwft(0, 0, '0, 0);
    chk("fwft.hold.dout", 64'(f_dout), 64'(32'hA5));
    cyc_fwft(0, 0, '0, 1);
    chk("fwft.pop.dvalid", 64'(f_dvalid), 64'(0));
    chk("fwft.pop.empty",  64'(f_empty),  64'(1));
    for (int i = 0; i < 30; i++) cyc_fwft(0, 1, WIDTH'(100 + i), 0);
    chk("fwft.burst.count", 64'(f_count), 64'(30));
    chk("fwft.burst.dout",  64'(f_dout),  64'(100));
    cyc_fwft(0, 1, WIDTH'(130), 1);
    chk("fwft.next.dout",  64'(f_dout),  64'(101));
    chk("fwft.next.count", 64'(f_count), 64'(30));
    cyc_fwft(1, 1, WIDTH'(131), 1);
    chk("fwft.midrst.count",  64'(f_count),  64'(0));
    chk("fwft.midrst.empty",  64'(f_empty),  64'(1));
    chk("fwft.midrst.ae",     64'(f_ae),     64'(1));
    chk("fwft.midrst.full",   64'(f_full),   64'(0));
    chk("fwft.midrst.af",     64'(f_af),     64'(0));
    chk("fwft.midrst.dvalid", 64'(f_dvalid), 64'(0));
    chk("fwft.midrst.dout",   64'(f_dout),   64'(0));
    chk("fwft.midrst.ovf",    64'(f_ovf),    64'(0));
    chk("fwft.midrst.unf",    64'(f_unf),    64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
